// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator: sequencer states, layer opcodes
// and the fixed DRAM region bases.
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_HDR_WAIT = 3'd2,
        S_LD_PROG  = 3'd3,
        S_START    = 3'd4,
        S_RUN      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // Layer opcodes double as engine ids; ENG_INV has no engine behind it.
    localparam logic [1:0] ENG_CONV = 2'd0;
    localparam logic [1:0] ENG_POOL = 2'd1;
    localparam logic [1:0] ENG_FC   = 2'd2;
    localparam logic [1:0] ENG_INV  = 2'd3;

    // DRAM memory map.
    localparam int IFMAP_BASE = 0;
    localparam int PARAM_BASE = 65536;
    localparam int OFMAP_BASE = 131072;
    localparam int PROG_BASE  = 196608;

endpackage

// File: rtl/dram_port_mux.sv
// Combinational selector that routes one engine's DRAM request slice onto the
// shared port. Everything is zero unless a grant is active.
module dram_port_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_ENG    = 3,
    parameter int GW         = 2
) (
    input  logic                          grant_vld_i,
    input  logic [GW-1:0]                 grant_i,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] addr_rd_i,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] addr_wr_i,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] data_wr_i,
    input  logic [NUM_ENG-1:0]            en_rd_i,
    input  logic [NUM_ENG-1:0]            en_wr_i,
    output logic [ADDR_WIDTH-1:0]         addr_rd_o,
    output logic [ADDR_WIDTH-1:0]         addr_wr_o,
    output logic [DATA_WIDTH-1:0]         data_wr_o,
    output logic                          en_rd_o,
    output logic                          en_wr_o
);

    // Pick the granted engine's slice; non-granted engines never reach the port.
    always_comb begin
        addr_rd_o = '0;
        addr_wr_o = '0;
        data_wr_o = '0;
        en_rd_o   = 1'b0;
        en_wr_o   = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (grant_vld_i && (grant_i == GW'(k))) begin
                addr_rd_o = addr_rd_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                addr_wr_o = addr_wr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                data_wr_o = data_wr_i[k*DATA_WIDTH +: DATA_WIDTH];
                en_rd_o   = en_rd_i[k];
                en_wr_o   = en_wr_i[k];
            end
        end
    end

endmodule

// File: rtl/layer_sched.sv
// Layer sequencer: fetches the layer program from DRAM, then starts each
// listed engine in turn and lends it the shared DRAM port until it finishes.
// Engine handshake: eng_enable is a one-cycle start pulse; the engine owns the
// DRAM port until it returns a one-cycle eng_done pulse.
module layer_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_ENG    = 3,
    parameter int MAX_LAYERS = 8,
    parameter int PROG_BASE  = 196608,
    parameter int TMO_WIDTH  = 20
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         dram_data_in,
    output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
    output logic [ADDR_WIDTH-1:0]         dram_addr_wr,
    output logic [DATA_WIDTH-1:0]         dram_data_wr,
    output logic                          dram_en_rd,
    output logic                          dram_en_wr,
    output logic [NUM_ENG-1:0]            eng_enable,
    input  logic [NUM_ENG-1:0]            eng_done,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out,
    input  logic [NUM_ENG-1:0]            eng_en_rd,
    input  logic [NUM_ENG-1:0]            eng_en_wr,
    output logic                          busy,
    output logic [2:0]                    cur_layer,
    output logic                          done,
    output logic                          err,
    output logic [2:0]                    dbg_state
);

    import cnn_pkg::*;

    localparam logic [3:0]           MAX_L4    = 4'(MAX_LAYERS);
    localparam logic [TMO_WIDTH-1:0] WDOG_LAST = ~TMO_WIDTH'(1);

    state_t               state_q, state_d;
    logic [3:0]           num_q, num_d;
    logic [3:0]           rd_cnt_q, rd_cnt_d;
    logic [2:0]           cur_q, cur_d;
    logic [TMO_WIDTH-1:0] wdog_q, wdog_d;
    logic                 err_q, err_d;
    logic [1:0]           prog_q [MAX_LAYERS];

    logic                  prog_we;
    logic [3:0]            ld_idx;
    logic [1:0]            cur_op;
    logic                  grant_vld;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] mux_addr_rd;
    logic                  mux_en_rd;
    logic                  unused_data;

    assign unused_data = ^dram_data_in[DATA_WIDTH-1:4];
    assign cur_op      = prog_q[cur_q];
    assign ld_idx      = rd_cnt_q - 4'd2;

    // Next-state logic, program-load reads and per-state outputs.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        rd_cnt_d   = rd_cnt_q;
        cur_d      = cur_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        prog_we    = 1'b0;
        rd_addr    = '0;
        rd_en      = 1'b0;
        grant_vld  = 1'b0;
        eng_enable = '0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (start) state_d = S_HDR;
            end
            S_HDR: begin
                rd_addr = ADDR_WIDTH'(PROG_BASE);
                rd_en   = 1'b1;
                state_d = S_HDR_WAIT;
            end
            S_HDR_WAIT: begin
                num_d = dram_data_in[3:0];
                if (dram_data_in[3:0] == 4'd0) begin
                    state_d = S_DONE;
                end else if (dram_data_in[3:0] > MAX_L4) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rd_cnt_d = 4'd1;
                    state_d  = S_LD_PROG;
                end
            end
            S_LD_PROG: begin
                // Reads run one ahead of captures because of the DRAM latency.
                if (rd_cnt_q <= num_q) begin
                    rd_addr = ADDR_WIDTH'(PROG_BASE) + ADDR_WIDTH'(rd_cnt_q);
                    rd_en   = 1'b1;
                end
                if (rd_cnt_q >= 4'd2) prog_we = 1'b1;
                rd_cnt_d = rd_cnt_q + 4'd1;
                if (rd_cnt_q == num_q + 4'd1) begin
                    cur_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                wdog_d = '0;
                if (cur_op == ENG_INV) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    eng_enable = NUM_ENG'(1) << cur_op;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                grant_vld = 1'b1;
                wdog_d    = wdog_q + TMO_WIDTH'(1);
                if (eng_done[cur_op]) begin
                    if ({1'b0, cur_q} == num_q - 4'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + 3'd1;
                        state_d = S_START;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and program register file.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            rd_cnt_q <= '0;
            cur_q    <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_LAYERS; i++) prog_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            rd_cnt_q <= rd_cnt_d;
            cur_q    <= cur_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
            if (prog_we) prog_q[ld_idx[2:0]] <= dram_data_in[1:0];
        end
    end

    dram_port_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_ENG    (NUM_ENG),
        .GW         (2)
    ) u_mux (
        .grant_vld_i (grant_vld),
        .grant_i     (cur_op),
        .addr_rd_i   (eng_addr_in),
        .addr_wr_i   (eng_addr_out),
        .data_wr_i   (eng_data_out),
        .en_rd_i     (eng_en_rd),
        .en_wr_i     (eng_en_wr),
        .addr_rd_o   (mux_addr_rd),
        .addr_wr_o   (dram_addr_wr),
        .data_wr_o   (dram_data_wr),
        .en_rd_o     (mux_en_rd),
        .en_wr_o     (dram_en_wr)
    );

    assign dram_addr_rd = grant_vld ? mux_addr_rd : rd_addr;
    assign dram_en_rd   = grant_vld ? mux_en_rd : rd_en;
    assign busy         = (state_q != S_IDLE);
    assign cur_layer    = cur_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: DRAM program model, simple engine model and
// per-scenario tasks with hand-derived cycle expectations (cycle 0 = start).
module tb_layer_sched;

    import cnn_pkg::*;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam int NE = 3;
    localparam logic [AW-1:0] PB = 18'h30000;

    logic             clk = 1'b0;
    logic             srstn = 1'b0;
    logic             start = 1'b0;
    logic [DW-1:0]    dram_data_in = '1;
    logic [AW-1:0]    dram_addr_rd, dram_addr_wr;
    logic [DW-1:0]    dram_data_wr;
    logic             dram_en_rd, dram_en_wr;
    logic [NE-1:0]    eng_enable;
    logic [NE-1:0]    eng_done;
    logic [NE*AW-1:0] eng_addr_in = '0;
    logic [NE*AW-1:0] eng_addr_out = '0;
    logic [NE*DW-1:0] eng_data_out = '0;
    logic [NE-1:0]    eng_en_rd = '0;
    logic [NE-1:0]    eng_en_wr = '0;
    logic             busy, done, err;
    logic [2:0]       cur_layer, dbg_state;

    logic [DW-1:0]    mem [16];
    logic [NE-1:0]    model_done = '0;
    logic [NE-1:0]    force_done = '0;
    logic             model_on = 1'b1;
    int               cnt [NE];
    int               checks = 0;
    int               errors = 0;

    assign eng_done = model_done | force_done;

    layer_sched #(.TMO_WIDTH(4)) dut (
        .clk          (clk),
        .srstn        (srstn),
        .start        (start),
        .dram_data_in (dram_data_in),
        .dram_addr_rd (dram_addr_rd),
        .dram_addr_wr (dram_addr_wr),
        .dram_data_wr (dram_data_wr),
        .dram_en_rd   (dram_en_rd),
        .dram_en_wr   (dram_en_wr),
        .eng_enable   (eng_enable),
        .eng_done     (eng_done),
        .eng_addr_in  (eng_addr_in),
        .eng_addr_out (eng_addr_out),
        .eng_data_out (eng_data_out),
        .eng_en_rd    (eng_en_rd),
        .eng_en_wr    (eng_en_wr),
        .busy         (busy),
        .cur_layer    (cur_layer),
        .done         (done),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // DRAM model: one-cycle read latency, all-ones for unread or unmapped words.
    always @(posedge clk) begin
        if (dram_en_rd && dram_addr_rd[AW-1:4] == PB[AW-1:4])
            dram_data_in <= mem[dram_addr_rd[3:0]];
        else
            dram_data_in <= '1;
    end

    // Engine model: done pulse 10 cycles after the enable pulse.
    always @(negedge clk) begin
        model_done = '0;
        for (int k = 0; k < NE; k++) begin
            if (!srstn || !model_on) begin
                cnt[k] = 0;
            end else begin
                if (cnt[k] != 0) begin
                    cnt[k] = cnt[k] - 1;
                    if (cnt[k] == 0) model_done[k] = 1'b1;
                end
                if (eng_enable[k]) cnt[k] = 10;
            end
        end
    end

    task automatic load_prog(input logic [DW-1:0] hdr, input logic [DW-1:0] p0, input logic [DW-1:0] p1);
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = hdr;
        mem[1] = p0;
        mem[2] = p1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b expected 0/0", done, err); end
        checks++; if (eng_enable !== 3'b000) begin errors++; $display("FAIL reset_enable got %b expected 000", eng_enable); end
        checks++; if (dram_en_rd !== 1'b0 || dram_en_wr !== 1'b0 || dram_addr_rd !== '0 || dram_addr_wr !== '0 || dram_data_wr !== '0) begin
            errors++; $display("FAIL reset_dram got en_rd=%b en_wr=%b ard=%h awr=%h d=%h expected all 0", dram_en_rd, dram_en_wr, dram_addr_rd, dram_addr_wr, dram_data_wr);
        end
        checks++; if (cur_layer !== 3'd0) begin errors++; $display("FAIL reset_cur_layer got %0d expected 0", cur_layer); end
        checks++; if (dbg_state !== 3'(S_IDLE)) begin errors++; $display("FAIL reset_state got %0d expected %0d", dbg_state, 3'(S_IDLE)); end
        srstn = 1'b1;
    endtask

    task automatic test_two_layers();
        logic [NE-1:0] exp_en;
        logic          exp_rd;
        logic [AW-1:0] exp_addr;
        logic [NE-1:0] exp_q [$];
        logic [NE-1:0] exp_pop;
        load_prog(32'd2, 32'd1, 32'd2);
        model_on = 1'b1;
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            if (c >= 1) begin
                exp_en = (c == 6) ? 3'b010 : (c == 17) ? 3'b100 : 3'b000;
                checks++; if (eng_enable !== exp_en) begin errors++; $display("FAIL two_layers_enable cycle %0d got %b expected %b", c, eng_enable, exp_en); end
                if (eng_enable !== 3'b000) begin
                    exp_pop = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
                    checks++; if (eng_enable !== exp_pop) begin errors++; $display("FAIL two_layers_order cycle %0d got %b expected %b", c, eng_enable, exp_pop); end
                end
                checks++; if (done !== (c == 28) || err !== 1'b0) begin errors++; $display("FAIL two_layers_done cycle %0d got %b/%b expected %b/0", c, done, err, (c == 28)); end
                checks++; if (busy !== (c <= 28)) begin errors++; $display("FAIL two_layers_busy cycle %0d got %b expected %b", c, busy, (c <= 28)); end
                exp_rd   = (c == 1) || (c == 3) || (c == 4);
                exp_addr = (c == 1) ? PB : (c == 3) ? PB + 18'd1 : (c == 4) ? PB + 18'd2 : '0;
                checks++; if (dram_en_rd !== exp_rd || dram_addr_rd !== exp_addr) begin
                    errors++; $display("FAIL two_layers_read cycle %0d got %b@%h expected %b@%h", c, dram_en_rd, dram_addr_rd, exp_rd, exp_addr);
                end
                if (c == 10 || c == 20) begin
                    checks++; if (cur_layer !== ((c == 10) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL two_layers_cur_layer cycle %0d got %0d expected %0d", c, cur_layer, (c == 10) ? 0 : 1); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL two_layers_missing_enables got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_empty_header();
        load_prog(32'd0, 32'd1, 32'd1);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            if (c >= 1) begin
                checks++; if (done !== (c == 3) || err !== 1'b0) begin errors++; $display("FAIL empty_done cycle %0d got %b/%b expected %b/0", c, done, err, (c == 3)); end
                checks++; if (eng_enable !== 3'b000) begin errors++; $display("FAIL empty_enable cycle %0d got %b expected 000", c, eng_enable); end
                checks++; if (busy !== (c <= 3)) begin errors++; $display("FAIL empty_busy cycle %0d got %b expected %b", c, busy, (c <= 3)); end
            end
        end
    endtask

    task automatic test_bad_header();
        load_prog(32'd9, 32'd1, 32'd1);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            if (c >= 1) begin
                checks++; if (done !== (c == 3) || err !== (c == 3)) begin errors++; $display("FAIL bad_hdr_done cycle %0d got %b/%b expected %b/%b", c, done, err, (c == 3), (c == 3)); end
                checks++; if (dram_en_rd !== (c == 1)) begin errors++; $display("FAIL bad_hdr_reads cycle %0d got %b expected %b", c, dram_en_rd, (c == 1)); end
            end
        end
    endtask

    task automatic test_invalid_opcode();
        load_prog(32'd2, 32'd1, 32'd3);
        model_on = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            if (c >= 1) begin
                checks++; if (eng_enable !== ((c == 6) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL inv_op_enable cycle %0d got %b expected %b", c, eng_enable, (c == 6) ? 3'b010 : 3'b000); end
                checks++; if (done !== (c == 18) || err !== (c == 18)) begin errors++; $display("FAIL inv_op_done cycle %0d got %b/%b expected %b/%b", c, done, err, (c == 18), (c == 18)); end
            end
        end
    endtask

    task automatic test_mux_isolation();
        load_prog(32'd1, 32'd1, 32'd0);
        model_on = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == 10);
            eng_addr_in = '0; eng_addr_out = '0; eng_data_out = '0;
            eng_en_rd = '0; eng_en_wr = '0; force_done = '0;
            if (c == 8) begin
                eng_en_wr             = 3'b001;
                eng_addr_out[0 +: AW] = 18'h01234;
                eng_addr_in[AW +: AW] = 18'h10005;
                eng_en_rd             = 3'b010;
                force_done            = 3'b001;
            end
            if (c == 9) begin
                eng_en_wr                 = 3'b011;
                eng_addr_out[0 +: AW]     = 18'h01234;
                eng_addr_out[AW +: AW]    = 18'h00abc;
                eng_data_out[DW +: DW]    = 32'hcafebabe;
                eng_data_out[2*DW +: DW]  = 32'hdeadbeef;
            end
            #1;
            if (c == 8) begin
                checks++; if (dram_en_wr !== 1'b0 || dram_addr_wr !== '0) begin errors++; $display("FAIL mux_foreign_wr got %b@%h expected 0@0", dram_en_wr, dram_addr_wr); end
                checks++; if (dram_en_rd !== 1'b1 || dram_addr_rd !== 18'h10005) begin errors++; $display("FAIL mux_granted_rd got %b@%h expected 1@10005", dram_en_rd, dram_addr_rd); end
            end
            if (c == 9) begin
                checks++; if (dram_en_wr !== 1'b1 || dram_addr_wr !== 18'h00abc || dram_data_wr !== 32'hcafebabe) begin
                    errors++; $display("FAIL mux_granted_wr got %b@%h=%h expected 1@00abc=cafebabe", dram_en_wr, dram_addr_wr, dram_data_wr);
                end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mux_spurious_done got busy=%b expected 1", busy); end
            end
            if (c == 11) begin
                checks++; if (dram_en_rd !== 1'b0 || dbg_state !== 3'(S_RUN)) begin errors++; $display("FAIL start_ignored got rd=%b state=%0d expected 0/%0d", dram_en_rd, dbg_state, 3'(S_RUN)); end
            end
            if (c >= 1) begin
                checks++; if (done !== (c == 16) || err !== 1'b0) begin errors++; $display("FAIL mux_done cycle %0d got %b/%b expected %b/0", c, done, err, (c == 16)); end
                checks++; if (busy !== (c <= 16)) begin errors++; $display("FAIL mux_busy cycle %0d got %b expected %b", c, busy, (c <= 16)); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        load_prog(32'd1, 32'd2, 32'd0);
        model_on = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            start = (c == 0);
            if (c == 9) begin
                srstn                   = 1'b0;
                eng_en_rd               = 3'b100;
                eng_addr_in[2*AW +: AW] = 18'h02222;
            end
            if (c == 11) begin
                srstn       = 1'b1;
                eng_en_rd   = '0;
                eng_addr_in = '0;
            end
            #1;
            if (c == 9) begin
                checks++; if (dram_en_rd !== 1'b1 || dram_addr_rd !== 18'h02222) begin errors++; $display("FAIL midrun_grant got %b@%h expected 1@02222", dram_en_rd, dram_addr_rd); end
            end
            if (c == 10) begin
                checks++; if (busy !== 1'b0 || eng_enable !== 3'b000 || cur_layer !== 3'd0) begin errors++; $display("FAIL midrun_abort got busy=%b en=%b layer=%0d expected 0/000/0", busy, eng_enable, cur_layer); end
                checks++; if (dram_en_rd !== 1'b0 || dram_addr_rd !== '0 || dram_en_wr !== 1'b0) begin errors++; $display("FAIL midrun_dram got %b@%h wr=%b expected 0@0 wr=0", dram_en_rd, dram_addr_rd, dram_en_wr); end
            end
        end
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            if (c == 1) begin
                checks++; if (dram_en_rd !== 1'b1 || dram_addr_rd !== PB) begin errors++; $display("FAIL restart_header got %b@%h expected 1@%h", dram_en_rd, dram_addr_rd, PB); end
            end
            if (c >= 1) begin
                checks++; if (eng_enable !== ((c == 5) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL restart_enable cycle %0d got %b expected %b", c, eng_enable, (c == 5) ? 3'b100 : 3'b000); end
                checks++; if (done !== (c == 16) || err !== 1'b0) begin errors++; $display("FAIL restart_done cycle %0d got %b/%b expected %b/0", c, done, err, (c == 16)); end
            end
        end
    endtask

    task automatic test_timeout();
        load_prog(32'd1, 32'd0, 32'd0);
        model_on = 1'b0;
        for (int c = 0; c <= 23; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            if (c >= 1) begin
                checks++; if (eng_enable !== ((c == 5) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL tmo_enable cycle %0d got %b expected %b", c, eng_enable, (c == 5) ? 3'b001 : 3'b000); end
                checks++; if (done !== (c == 21) || err !== (c == 21)) begin errors++; $display("FAIL tmo_done cycle %0d got %b/%b expected %b/%b", c, done, err, (c == 21), (c == 21)); end
                checks++; if (busy !== (c <= 21)) begin errors++; $display("FAIL tmo_busy cycle %0d got %b expected %b", c, busy, (c <= 21)); end
            end
        end
        model_on = 1'b1;
    endtask

    initial begin
        test_reset();
        repeat (2) @(negedge clk);
        test_two_layers();
        repeat (2) @(negedge clk);
        test_empty_header();
        repeat (2) @(negedge clk);
        test_bad_header();
        repeat (2) @(negedge clk);
        test_invalid_opcode();
        repeat (2) @(negedge clk);
        test_mux_isolation();
        repeat (2) @(negedge clk);
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        test_timeout();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_sched.md
Name: layer_sched

Overview:
- Top-level layer sequencer for the CNN accelerator.
- After a start pulse, it reads a small layer program from DRAM at PROG_BASE. It then runs the listed engines (conv, max_pool, fc) one at a time.
- While an engine runs, the sequencer grants that engine the single shared DRAM port and muxes its address, data and enable signals onto the port.
- It pulses done, or done plus err, when the program finishes.

Parameters:
- DATA_WIDTH, 32, DRAM word width.
- ADDR_WIDTH, 18, DRAM address width.
- NUM_ENG, 3, number of engines. Engine id 0 = conv, 1 = max_pool, 2 = fc.
- MAX_LAYERS, 8, depth of the program register file.
- PROG_BASE, 196608, DRAM address of the program header word.
- TMO_WIDTH, 20, width of the per-layer watchdog counter.

Ports:
- clk  in  1  clock
- srstn  in  1  synchronous active-low reset
- start  in  1  one-cycle start request
- dram_data_in  in  DATA_WIDTH  DRAM read data, valid one cycle after the read address
- dram_addr_rd  out  ADDR_WIDTH  DRAM read address
- dram_addr_wr  out  ADDR_WIDTH  DRAM write address
- dram_data_wr  out  DATA_WIDTH  DRAM write data
- dram_en_rd  out  1  DRAM read enable
- dram_en_wr  out  1  DRAM write enable
- eng_enable  out  NUM_ENG  one-hot start pulse to an engine
- eng_done  in  NUM_ENG  engine done pulses
- eng_addr_in  in  NUM_ENG*ADDR_WIDTH  engine read addresses; engine k occupies slice k
- eng_addr_out  in  NUM_ENG*ADDR_WIDTH  engine write addresses
- eng_data_out  in  NUM_ENG*DATA_WIDTH  engine write data
- eng_en_rd  in  NUM_ENG  engine read enables
- eng_en_wr  in  NUM_ENG  engine write enables
- busy  out  1  high in every state except IDLE
- cur_layer  out  3  index of the running layer
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; high only in the same cycle as done

Behaviour:
- Reset (srstn=0 at a clock edge):
  - state = IDLE; all outputs 0; prog regs, layer count, counters and watchdog cleared.
  - Reset mid-run aborts immediately; no grant is held on the following cycle.
- DRAM read model: address driven with en_rd in cycle t; dram_data_in is sampled at cycle t+1.
- State IDLE:
  - On start=1, go to HDR.
  - start is ignored in every other state.
- State HDR (1 cycle):
  - dram_addr_rd = PROG_BASE, dram_en_rd = 1.
  - Go to HDR_WAIT.
- State HDR_WAIT (1 cycle):
  - num_layers = dram_data_in[3:0].
  - If num_layers = 0, go to DONE with err = 0.
  - If num_layers > MAX_LAYERS, go to DONE with err = 1.
  - Otherwise go to LD_PROG with rd_cnt = 1.
- State LD_PROG:
  - While rd_cnt <= num_layers: dram_addr_rd = PROG_BASE + rd_cnt, dram_en_rd = 1.
  - In each cycle with rd_cnt >= 2, capture prog[rd_cnt-2] = dram_data_in[1:0].
  - rd_cnt increments every cycle.
  - After the cycle that captures prog[num_layers-1] (rd_cnt = num_layers+1, no read issued), go to START with cur_layer = 0.
  - State length is num_layers+1 cycles.
- State START (1 cycle):
  - If prog[cur_layer] = 3 (invalid opcode), go to DONE with err = 1.
  - Otherwise eng_enable[prog[cur_layer]] = 1 for this cycle only, then go to RUN.
  - Watchdog is cleared.
- State RUN:
  - Grant engine g = prog[cur_layer]. DRAM outputs are a pure combinational mux of engine g's slices (addr_in → dram_addr_rd, addr_out → dram_addr_wr, data_out → dram_data_wr, en_rd/en_wr → dram_en_rd/dram_en_wr).
  - Non-granted engines' requests and done pulses are ignored.
  - On eng_done[g]=1: if cur_layer = num_layers-1, go to DONE; otherwise cur_layer++ and go to START.
  - The watchdog increments every RUN cycle. If it reaches all-ones, go to DONE with err = 1.
- Outside RUN and the read states: all dram_* outputs are 0.
- State DONE (1 cycle):
  - done = 1, err = registered error flag.
  - Go to IDLE; the error flag clears on entry to IDLE.
- Overlaps:
  - The first layer starts 4+num_layers cycles after start.
  - Consecutive layers have a 1-cycle START bubble.
  - Layers may reuse the same engine back-to-back.

Decomposition:
- Shared package (cnn_pkg) holds:
  - state encodings;
  - opcode constants ENG_CONV=0, ENG_POOL=1, ENG_FC=2, ENG_INV=3;
  - PROG_BASE and the existing PARAM/OFMAP/IFMAP base constants.
- One natural sub-module: dram_port_mux. It is combinational: grant index → selected engine's slice, zeroed when not granted. The FSM, program register file and watchdog remain in layer_sched.

Test Plan:
- Header=2, prog={1,2}, engine model asserts done 10 cycles after enable:
  - eng_enable = 3'b010 at cycle 6, then 3'b100 one cycle after pool's done.
  - done=1, err=0 exactly one cycle after fc's done.
- Header=0 → done=1 with err=0 at cycle 3 after start; eng_enable never asserted.
- Header=9 → done with err=1; no LD_PROG reads; prog={1,3} → pool runs, then done with err=1 at the START of layer 1.
- During a pool RUN, drive engine 0 en_wr=1 with addr 0x1234 → dram_en_wr stays 0. Engine 1 addr 0x10005 appears on dram_addr_rd the same cycle; a spurious eng_done[0] is ignored.
- start pulsed during RUN → ignored. srstn=0 mid-RUN → next cycle busy=0, all dram_*=0, and a fresh start rereads the header.
- TMO_WIDTH=4, engine never asserts done → done=1 with err=1 after 15 RUN cycles.
